// File: rtl/multi_inclock_pkg.sv
// multi_inclock_pkg
// Shared definitions for the multi-player interval-guessing game:
//   - game state encoding (matches the STATE output codes)
//   - grade encoding (matches the GRADE output codes)
//   - common widths and the tick-period helper used by the prescaler
package multi_inclock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CD   = 2'd1,
        ST_MEAS = 2'd2,
        ST_RES  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GR_JUST = 2'd0,
        GR_GOOD = 2'd1,
        GR_SOSO = 2'd2,
        GR_BAD  = 2'd3
    } grade_t;

    // Hundredths counter width (holds 0..TICK_HZ-1 for TICK_HZ up to 128)
    localparam int CSEC_W   = 7;
    // Target seconds width
    localparam int TARGET_W = 4;

    // Number of clock cycles per measurement tick, stretched by 2^shift
    function automatic int tick_period(input int clk_hz, input int tick_hz, input int shift);
        return (clk_hz / tick_hz) << shift;
    endfunction

endpackage

// File: rtl/multi_inclock_lane.sv
// inclock_lane
// One player lane: stop-button synchroniser and falling-edge detect,
// seconds/hundredths counters that freeze once the player stops, and the
// error/grade computation against the latched target.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   stop_n     : raw active-low stop button for this player
//   clear      : synchronous clear of counts and stopped flag
//   run_en     : lane may count and accept a stop (measurement running)
//   tick       : one-cycle measurement tick
//   target     : latched target seconds
//   stop_fall  : registered stop button falling edge (used for game exit)
//   stopped    : lane was frozen by its button
//   timed_out  : lane still running with seconds saturated
//   sec, csec  : lane seconds and hundredths
//   err        : |elapsed - target| in ticks
//   grade      : JUSt/gOOd/SOSO/bAd code
module inclock_lane
    import multi_inclock_pkg::*;
#(
    parameter int TICK_HZ  = 100,
    parameter int SEC_W    = 5,
    parameter int G1_TICKS = 10,
    parameter int G2_TICKS = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stop_n,
    input  logic                  clear,
    input  logic                  run_en,
    input  logic                  tick,
    input  logic [TARGET_W-1:0]   target,
    output logic                  stop_fall,
    output logic                  stopped,
    output logic                  timed_out,
    output logic [SEC_W-1:0]      sec,
    output logic [CSEC_W-1:0]     csec,
    output logic [SEC_W+7:0]      err,
    output logic [1:0]            grade
);

    localparam int EW = SEC_W + 8;
    localparam logic [SEC_W-1:0]  SEC_MAX   = '1;
    localparam logic [CSEC_W-1:0] CSEC_LAST = CSEC_W'(TICK_HZ - 1);
    localparam logic [EW-1:0]     TICK_EW   = EW'(TICK_HZ);
    localparam logic [EW-1:0]     G1_EW     = EW'(G1_TICKS);
    localparam logic [EW-1:0]     G2_EW     = EW'(G2_TICKS);

    logic              stop_sync_q, stop_sync_d;
    logic              stop_prev_q, stop_prev_d;
    logic              stopped_q, stopped_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [CSEC_W-1:0] csec_q, csec_d;

    logic [EW-1:0]     elapsed;
    logic [EW-1:0]     target_ticks;
    logic [EW-1:0]     err_v;
    grade_t            grade_v;

    // Button history is deliberately not cleared with the game so a button
    // held across a state change cannot produce a fresh edge.
    assign stop_fall = stop_prev_q & ~stop_sync_q;

    // Counter update: a stop edge wins over a coincident tick, so the
    // frozen value never includes the tick of the stopping cycle.
    always_comb begin
        stop_sync_d = stop_n;
        stop_prev_d = stop_sync_q;
        stopped_d   = stopped_q;
        sec_d       = sec_q;
        csec_d      = csec_q;
        if (clear) begin
            stopped_d = 1'b0;
            sec_d     = '0;
            csec_d    = '0;
        end else if (run_en && !stopped_q) begin
            if (stop_fall) begin
                stopped_d = 1'b1;
            end else if (tick) begin
                if (csec_q >= CSEC_LAST) begin
                    csec_d = '0;
                    if (sec_q != SEC_MAX) begin
                        sec_d = sec_q + SEC_W'(1);
                    end
                end else begin
                    csec_d = csec_q + CSEC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stop_sync_q <= 1'b0;
            stop_prev_q <= 1'b0;
            stopped_q   <= 1'b0;
            sec_q       <= '0;
            csec_q      <= '0;
        end else begin
            stop_sync_q <= stop_sync_d;
            stop_prev_q <= stop_prev_d;
            stopped_q   <= stopped_d;
            sec_q       <= sec_d;
            csec_q      <= csec_d;
        end
    end

    // Symmetric error against the target, then graded by threshold
    always_comb begin
        elapsed      = EW'(sec_q) * TICK_EW + EW'(csec_q);
        target_ticks = EW'(target) * TICK_EW;
        if (elapsed >= target_ticks) begin
            err_v = elapsed - target_ticks;
        end else begin
            err_v = target_ticks - elapsed;
        end
        if (err_v == '0) begin
            grade_v = GR_JUST;
        end else if (err_v <= G1_EW) begin
            grade_v = GR_GOOD;
        end else if (err_v <= G2_EW) begin
            grade_v = GR_SOSO;
        end else begin
            grade_v = GR_BAD;
        end
    end

    assign stopped   = stopped_q;
    assign timed_out = !stopped_q && (sec_q == SEC_MAX);
    assign sec       = sec_q;
    assign csec      = csec_q;
    assign err       = err_v;
    assign grade     = grade_v;

endmodule

// File: rtl/multi_inclock.sv
// multi_inclock
// N-player interval-guessing game controller. Shows a target, runs a
// countdown, then times every player in parallel until each presses STOP,
// grades them and registers the winner mask.
// Ports:
//   CLK, RST   : clock and synchronous active-high reset
//   START_N    : active-low start/restart button
//   STOP_N     : active-low per-player stop buttons
//   NO         : target seconds, 0 selects a free-running pseudo-random target
//   DEBUG      : stretch the measurement tick by 2^DBG_SHIFT
//   STATE      : 0 IDLE, 1 COUNTDOWN, 2 MEASURE, 3 RESULT
//   TARGET     : latched target seconds
//   SEC, CSEC  : per-lane seconds / hundredths, lane i at [i*W +: W]
//   GRADE      : per-lane grade code, 2 bits per lane
//   STOPPED    : lane froze by its own button
//   WIN        : winner mask, meaningful in RESULT
//   COUNT_LED  : countdown bar, one bit per second
module multi_inclock
    import multi_inclock_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 100,
    parameter int N_PLAYER  = 4,
    parameter int SEC_W     = 5,
    parameter int CD_SEC    = 3,
    parameter int G1_TICKS  = 10,
    parameter int G2_TICKS  = 20,
    parameter int DBG_SHIFT = 5
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        START_N,
    input  logic [N_PLAYER-1:0]         STOP_N,
    input  logic [3:0]                  NO,
    input  logic                        DEBUG,
    output logic [1:0]                  STATE,
    output logic [3:0]                  TARGET,
    output logic [N_PLAYER*SEC_W-1:0]   SEC,
    output logic [N_PLAYER*7-1:0]       CSEC,
    output logic [N_PLAYER*2-1:0]       GRADE,
    output logic [N_PLAYER-1:0]         STOPPED,
    output logic [N_PLAYER-1:0]         WIN,
    output logic [CD_SEC-1:0]           COUNT_LED
);

    localparam int EW       = SEC_W + 8;
    localparam int PER_NORM = tick_period(CLK_HZ, TICK_HZ, 0);
    localparam int PER_DBG  = tick_period(CLK_HZ, TICK_HZ, DBG_SHIFT);
    localparam int TP_W     = $clog2(PER_DBG) + 1;
    localparam int CD_W     = $clog2(CLK_HZ) + 1;
    localparam logic [TP_W-1:0] TP_LAST_NORM = TP_W'(PER_NORM - 1);
    localparam logic [TP_W-1:0] TP_LAST_DBG  = TP_W'(PER_DBG - 1);
    localparam logic [CD_W-1:0] CD_LAST      = CD_W'(CLK_HZ - 1);

    state_t                state_q, state_d;
    logic [TARGET_W-1:0]   target_q, target_d;
    logic [CD_SEC-1:0]     count_led_q, count_led_d;
    logic [CD_W-1:0]       cd_presc_q, cd_presc_d;
    logic [TP_W-1:0]       tick_presc_q, tick_presc_d;
    logic [N_PLAYER-1:0]   win_q, win_d;
    logic                  start_sync_q, start_sync_d;
    logic                  start_prev_q, start_prev_d;

    logic                  start_fall;
    logic                  any_stop_fall;
    logic                  all_stopped;
    logic                  timeout;
    logic                  meas_done;
    logic                  run_en;
    logic                  lane_clear;
    logic                  tick;
    logic [TP_W-1:0]       tick_last;
    logic [EW-1:0]         min_err;
    logic [N_PLAYER-1:0]   win_v;

    logic [N_PLAYER-1:0]   stop_fall;
    logic [N_PLAYER-1:0]   stopped_v;
    logic [N_PLAYER-1:0]   timed_out;
    logic [EW-1:0]         lane_err [N_PLAYER];

    genvar g;
    generate
        for (g = 0; g < N_PLAYER; g++) begin : g_lane
            inclock_lane #(
                .TICK_HZ  (TICK_HZ),
                .SEC_W    (SEC_W),
                .G1_TICKS (G1_TICKS),
                .G2_TICKS (G2_TICKS)
            ) u_lane (
                .clk       (CLK),
                .rst       (RST),
                .stop_n    (STOP_N[g]),
                .clear     (lane_clear),
                .run_en    (run_en),
                .tick      (tick),
                .target    (target_q),
                .stop_fall (stop_fall[g]),
                .stopped   (stopped_v[g]),
                .timed_out (timed_out[g]),
                .sec       (SEC[g*SEC_W +: SEC_W]),
                .csec      (CSEC[g*7 +: 7]),
                .err       (lane_err[g]),
                .grade     (GRADE[g*2 +: 2])
            );
        end
    endgenerate

    assign start_fall    = start_prev_q & ~start_sync_q;
    assign any_stop_fall = |stop_fall;
    assign all_stopped   = &stopped_v;
    assign timeout       = |timed_out;
    assign meas_done     = all_stopped || timeout;
    // Lanes are frozen in the cycle the measurement ends so WIN is taken
    // from exactly the counts that stay on display.
    assign run_en        = (state_q == ST_MEAS) && !meas_done;
    // DEBUG is live; the >= compare tolerates a shrinking limit mid-count.
    assign tick_last     = DEBUG ? TP_LAST_DBG : TP_LAST_NORM;

    // Smallest error over stopped lanes; every lane matching it wins
    always_comb begin
        min_err = '1;
        win_v   = '0;
        for (int i = 0; i < N_PLAYER; i++) begin
            if (stopped_v[i] && (lane_err[i] < min_err)) begin
                min_err = lane_err[i];
            end
        end
        for (int i = 0; i < N_PLAYER; i++) begin
            win_v[i] = stopped_v[i] && (lane_err[i] == min_err);
        end
    end

    // Game sequencing: target selection, countdown, tick generation and
    // result handling all hang off the state register.
    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        count_led_d  = count_led_q;
        cd_presc_d   = cd_presc_q;
        tick_presc_d = tick_presc_q;
        win_d        = win_q;
        start_sync_d = START_N;
        start_prev_d = start_sync_q;
        lane_clear   = 1'b0;
        tick         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_fall) begin
                    state_d     = ST_CD;
                    count_led_d = '1;
                    cd_presc_d  = '0;
                end else if (NO != 4'd0) begin
                    target_d = NO;
                end else if ((target_q == 4'd15) || (target_q == 4'd0)) begin
                    target_d = 4'd1;
                end else begin
                    target_d = target_q + 4'd1;
                end
            end
            ST_CD: begin
                if (count_led_q == '0) begin
                    state_d      = ST_MEAS;
                    tick_presc_d = '0;
                    lane_clear   = 1'b1;
                end else if (cd_presc_q >= CD_LAST) begin
                    cd_presc_d  = '0;
                    count_led_d = count_led_q << 1;
                end else begin
                    cd_presc_d = cd_presc_q + CD_W'(1);
                end
            end
            ST_MEAS: begin
                if (meas_done) begin
                    state_d = ST_RES;
                    win_d   = win_v;
                end else if (tick_presc_q >= tick_last) begin
                    tick_presc_d = '0;
                    tick         = 1'b1;
                end else begin
                    tick_presc_d = tick_presc_q + TP_W'(1);
                end
            end
            ST_RES: begin
                if (start_fall || any_stop_fall) begin
                    state_d     = ST_IDLE;
                    target_d    = '0;
                    count_led_d = '0;
                    win_d       = '0;
                    lane_clear  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            target_q     <= '0;
            count_led_q  <= '0;
            cd_presc_q   <= '0;
            tick_presc_q <= '0;
            win_q        <= '0;
            start_sync_q <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            count_led_q  <= count_led_d;
            cd_presc_q   <= cd_presc_d;
            tick_presc_q <= tick_presc_d;
            win_q        <= win_d;
            start_sync_q <= start_sync_d;
            start_prev_q <= start_prev_d;
        end
    end

    assign STATE     = state_q;
    assign TARGET    = target_q;
    assign STOPPED   = stopped_v;
    assign WIN       = win_q;
    assign COUNT_LED = count_led_q;

endmodule

// File: tb/tb_multi_inclock.sv
// tb_multi_inclock
// Directed bench for multi_inclock with a fast clock (1 kHz nominal,
// 100 ticks/s, two players, 3-bit seconds so timeout arrives at 7 s).
// Every step is cycle-counted from the edge where the state changes.
module tb_multi_inclock;

    logic       CLK;
    logic       RST;
    logic       START_N;
    logic [1:0] STOP_N;
    logic [3:0] NO;
    logic       DEBUG;
    logic [1:0] STATE;
    logic [3:0] TARGET;
    logic [5:0] SEC;
    logic [13:0] CSEC;
    logic [3:0] GRADE;
    logic [1:0] STOPPED;
    logic [1:0] WIN;
    logic [2:0] COUNT_LED;

    int assertion_count;
    int failure_count;

    multi_inclock #(
        .CLK_HZ    (1000),
        .TICK_HZ   (100),
        .N_PLAYER  (2),
        .SEC_W     (3),
        .CD_SEC    (3),
        .G1_TICKS  (10),
        .G2_TICKS  (20),
        .DBG_SHIFT (5)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START_N   (START_N),
        .STOP_N    (STOP_N),
        .NO        (NO),
        .DEBUG     (DEBUG),
        .STATE     (STATE),
        .TARGET    (TARGET),
        .SEC       (SEC),
        .CSEC      (CSEC),
        .GRADE     (GRADE),
        .STOPPED   (STOPPED),
        .WIN       (WIN),
        .COUNT_LED (COUNT_LED)
    );

    // Free-running clock, 10 time units per cycle
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance n rising edges and settle 1 unit past the last one
    task automatic waitCycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drive all player-facing inputs at once
    task automatic applyStimulus(input logic start_n, input logic [1:0] stop_n,
                                 input logic [3:0] no, input logic debug);
        START_N = start_n;
        STOP_N  = stop_n;
        NO      = no;
        DEBUG   = debug;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertion_count++;
        assert (observed === expected) else begin
            failure_count++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Linear sequence of directed steps
    initial begin
        assertion_count = 0;
        failure_count   = 0;
        RST = 1'b1;
        applyStimulus(1'b1, 2'b11, 4'd2, 1'b0);
        waitCycles(2);
        checkOutput("reset_state", 32'(STATE), 32'd0);
        checkOutput("reset_target", 32'(TARGET), 32'd0);
        checkOutput("reset_led", 32'(COUNT_LED), 32'd0);
        RST = 1'b0;
        waitCycles(3);
        checkOutput("idle_target_no2", 32'(TARGET), 32'd2);

        // Game 1: NO=2, exact stop on lane0, 2.12 s on lane1
        START_N = 1'b0;
        waitCycles(2);
        checkOutput("g1_state_cd", 32'(STATE), 32'd1);
        checkOutput("g1_led_111", 32'(COUNT_LED), 32'd7);
        START_N = 1'b1;
        waitCycles(999);
        checkOutput("g1_led_still_111", 32'(COUNT_LED), 32'd7);
        waitCycles(1);
        checkOutput("g1_led_110", 32'(COUNT_LED), 32'd6);
        waitCycles(1000);
        checkOutput("g1_led_100", 32'(COUNT_LED), 32'd4);
        waitCycles(1000);
        checkOutput("g1_led_000", 32'(COUNT_LED), 32'd0);
        checkOutput("g1_still_cd", 32'(STATE), 32'd1);
        waitCycles(1);
        checkOutput("g1_state_meas", 32'(STATE), 32'd2);
        checkOutput("g1_counts_clear", 32'(CSEC), 32'd0);
        waitCycles(2003);
        STOP_N = 2'b10;
        waitCycles(2);
        checkOutput("g1_stopped_01", 32'(STOPPED), 32'd1);
        checkOutput("g1_sec0", 32'(SEC[2:0]), 32'd2);
        checkOutput("g1_csec0", 32'(CSEC[6:0]), 32'd0);
        waitCycles(118);
        STOP_N = 2'b00;
        waitCycles(2);
        waitCycles(1);
        checkOutput("g1_state_res", 32'(STATE), 32'd3);
        checkOutput("g1_sec1", 32'(SEC[5:3]), 32'd2);
        checkOutput("g1_csec1", 32'(CSEC[13:7]), 32'd12);
        checkOutput("g1_grade0", 32'(GRADE[1:0]), 32'd0);
        checkOutput("g1_grade1", 32'(GRADE[3:2]), 32'd2);
        checkOutput("g1_win", 32'(WIN), 32'd1);
        STOP_N = 2'b11;
        NO = 4'd3;
        waitCycles(3);
        checkOutput("g1_res_hold", 32'(STATE), 32'd3);
        START_N = 1'b0;
        waitCycles(2);
        checkOutput("g1_exit_state", 32'(STATE), 32'd0);
        checkOutput("g1_exit_win", 32'(WIN), 32'd0);
        checkOutput("g1_exit_stopped", 32'(STOPPED), 32'd0);
        checkOutput("g1_exit_sec", 32'(SEC), 32'd0);
        checkOutput("g1_exit_target", 32'(TARGET), 32'd0);
        START_N = 1'b1;
        waitCycles(3);
        checkOutput("g2_target_no3", 32'(TARGET), 32'd3);

        // Game 2: NO=3, 2.91 s and 3.09 s are equally good
        START_N = 1'b0;
        waitCycles(2);
        START_N = 1'b1;
        waitCycles(3001);
        checkOutput("g2_state_meas", 32'(STATE), 32'd2);
        waitCycles(2913);
        STOP_N = 2'b10;
        waitCycles(2);
        checkOutput("g2_sec0", 32'(SEC[2:0]), 32'd2);
        checkOutput("g2_csec0", 32'(CSEC[6:0]), 32'd91);
        waitCycles(178);
        STOP_N = 2'b00;
        waitCycles(3);
        checkOutput("g2_state_res", 32'(STATE), 32'd3);
        checkOutput("g2_sec1", 32'(SEC[5:3]), 32'd3);
        checkOutput("g2_csec1", 32'(CSEC[13:7]), 32'd9);
        checkOutput("g2_grades", 32'(GRADE), 32'h5);
        checkOutput("g2_win", 32'(WIN), 32'd3);
        STOP_N = 2'b11;
        NO = 4'd2;
        waitCycles(3);
        STOP_N = 2'b10;
        waitCycles(2);
        checkOutput("g2_exit_by_stop", 32'(STATE), 32'd0);
        STOP_N = 2'b11;
        waitCycles(3);

        // Game 3: stop coincident with a tick, then lane1 times out
        START_N = 1'b0;
        waitCycles(2);
        START_N = 1'b1;
        waitCycles(3001);
        checkOutput("g3_state_meas", 32'(STATE), 32'd2);
        waitCycles(48);
        STOP_N = 2'b10;
        waitCycles(2);
        checkOutput("g3_stop_excl_tick", 32'(CSEC[6:0]), 32'd4);
        checkOutput("g3_lane1_ticked", 32'(CSEC[13:7]), 32'd5);
        checkOutput("g3_stopped_01", 32'(STOPPED), 32'd1);
        STOP_N = 2'b11;
        waitCycles(6950);
        checkOutput("g3_pre_timeout", 32'(STATE), 32'd2);
        checkOutput("g3_sec1_max", 32'(SEC[5:3]), 32'd7);
        waitCycles(1);
        checkOutput("g3_timeout_res", 32'(STATE), 32'd3);
        checkOutput("g3_grade1_bad", 32'(GRADE[3:2]), 32'd3);
        checkOutput("g3_grade0_bad", 32'(GRADE[1:0]), 32'd3);
        checkOutput("g3_stopped", 32'(STOPPED), 32'd1);
        checkOutput("g3_win", 32'(WIN), 32'd1);
        checkOutput("g3_csec1_frozen", 32'(CSEC[13:7]), 32'd0);

        // Game 4: pseudo-random target cycles 1..15 from the cleared value
        NO = 4'd0;
        START_N = 1'b0;
        waitCycles(2);
        checkOutput("g4_exit_state", 32'(STATE), 32'd0);
        checkOutput("g4_target_cleared", 32'(TARGET), 32'd0);
        START_N = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            waitCycles(1);
            checkOutput("g4_random_target", 32'(TARGET), 32'(((k - 1) % 15) + 1));
        end
        DEBUG = 1'b1;
        START_N = 1'b0;
        waitCycles(2);
        checkOutput("g4_state_cd", 32'(STATE), 32'd1);
        checkOutput("g4_target_frozen", 32'(TARGET), 32'd6);
        START_N = 1'b1;
        waitCycles(3001);
        checkOutput("g4_state_meas", 32'(STATE), 32'd2);
        waitCycles(319);
        checkOutput("g4_dbg_no_tick", 32'(CSEC[6:0]), 32'd0);
        waitCycles(1);
        checkOutput("g4_dbg_tick1", 32'(CSEC[6:0]), 32'd1);
        waitCycles(320);
        checkOutput("g4_dbg_tick2", 32'(CSEC), 32'((2 << 7) | 2));

        // Reset mid-measurement with START held low through it
        START_N = 1'b0;
        RST = 1'b1;
        waitCycles(1);
        checkOutput("rst_mid_state", 32'(STATE), 32'd0);
        checkOutput("rst_mid_sec", 32'(SEC), 32'd0);
        checkOutput("rst_mid_csec", 32'(CSEC), 32'd0);
        checkOutput("rst_mid_led", 32'(COUNT_LED), 32'd0);
        checkOutput("rst_mid_win", 32'(WIN), 32'd0);
        RST = 1'b0;
        DEBUG = 1'b0;
        waitCycles(6);
        checkOutput("held_start_no_game", 32'(STATE), 32'd0);
        START_N = 1'b1;
        waitCycles(2);
        START_N = 1'b0;
        waitCycles(2);
        checkOutput("start_after_release", 32'(STATE), 32'd1);
        START_N = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", assertion_count, failure_count);
        $finish;
    end

endmodule
